// File: rtl/ram_loader.sv
// ram_loader: turns a length-prefixed byte stream into little-endian RAM word writes
// and holds the core in reset while loading. Optional trailing checksum: RAM_LOADER_CHECKSUM_EN.
module ram_loader #(
    parameter int DW        = 32,
    parameter int AW        = 12,
    parameter int MEM_NUM   = 4096,
    parameter int BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          w_en,
    output logic [AW-1:0] w_addr_o,
    output logic [DW-1:0] w_data_o,
    output logic          hold_o,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   word_cnt
);
    localparam int BPW = DW / 8;
    localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;

`ifdef RAM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CHK, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DONE, S_ERR} state_t;
`endif

    state_t        state_q;
    logic          hdr_idx_q;
    logic [7:0]    len_lo_q;
    logic [15:0]   len_q;
    logic [IW-1:0] byte_idx_q;
    logic [DW-1:0] word_q;
    logic          ready_q, busy_q, hold_q, done_q, err_q, w_en_q;
    logic [AW-1:0] w_addr_q;
    logic [DW-1:0] w_data_q;
    logic [AW:0]   cnt_q;

    logic          hs, last_byte, last_word, len_zero, len_bad;
    logic [15:0]   len_d;
    logic [DW-1:0] word_d;
    logic [AW:0]   cnt_d;
`ifdef RAM_LOADER_CHECKSUM_EN
    logic [7:0]    sum_q, sum_d;
`endif

    always_comb begin
        hs        = in_valid && ready_q;
        len_d     = {in_data, len_lo_q};
        len_zero  = (len_d == 16'd0);
        len_bad   = (32'(len_d) > 32'(MEM_NUM));
        word_d    = word_q;
        word_d[8*int'(byte_idx_q) +: 8] = in_data;
        last_byte = (byte_idx_q == IW'(BPW - 1));
        cnt_d     = cnt_q + (AW+1)'(1);
        last_word = (32'(cnt_d) == 32'(len_q));
`ifdef RAM_LOADER_CHECKSUM_EN
        sum_d     = sum_q + in_data;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            hdr_idx_q  <= 1'b0;
            len_lo_q   <= '0;
            len_q      <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            w_en_q     <= 1'b0;
            w_addr_q   <= '0;
            w_data_q   <= '0;
            cnt_q      <= '0;
`ifdef RAM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            w_en_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_q    <= S_HDR;
                        ready_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        hold_q     <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        cnt_q      <= '0;
                        hdr_idx_q  <= 1'b0;
                        byte_idx_q <= '0;
`ifdef RAM_LOADER_CHECKSUM_EN
                        sum_q      <= '0;
`endif
                    end
                end
                S_HDR: begin
                    if (hs) begin
                        hdr_idx_q <= 1'b1;
                        len_lo_q  <= in_data;
                        if (hdr_idx_q) begin
                            len_q <= len_d;
                            if (len_bad) begin
                                state_q <= S_ERR;
                                ready_q <= 1'b0;
                                busy_q  <= 1'b0;
                                hold_q  <= 1'b0;
                                err_q   <= 1'b1;
                            end else if (len_zero) begin
`ifdef RAM_LOADER_CHECKSUM_EN
                                state_q <= S_CHK;
`else
                                state_q <= S_DONE;
                                ready_q <= 1'b0;
                                busy_q  <= 1'b0;
                                hold_q  <= 1'b0;
                                done_q  <= 1'b1;
`endif
                            end else begin
                                state_q <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (hs) begin
                        word_q     <= word_d;
                        byte_idx_q <= last_byte ? '0 : byte_idx_q + IW'(1);
`ifdef RAM_LOADER_CHECKSUM_EN
                        sum_q      <= sum_d;
`endif
                        if (last_byte) begin
                            // address wraps silently modulo 2^AW
                            w_en_q   <= 1'b1;
                            w_addr_q <= AW'(BASE_ADDR) + cnt_q[AW-1:0];
                            w_data_q <= word_d;
                            cnt_q    <= cnt_d;
                            if (last_word) begin
`ifdef RAM_LOADER_CHECKSUM_EN
                                state_q <= S_CHK;
`else
                                state_q <= S_DONE;
                                ready_q <= 1'b0;
                                busy_q  <= 1'b0;
                                hold_q  <= 1'b0;
                                done_q  <= 1'b1;
`endif
                            end
                        end
                    end
                end
`ifdef RAM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (hs) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b0;
                        hold_q  <= 1'b0;
                        if (sum_d == 8'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready = ready_q;
    assign w_en     = w_en_q;
    assign w_addr_o = w_addr_q;
    assign w_data_o = w_data_q;
    assign hold_o   = hold_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign word_cnt = cnt_q;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: two instances (BASE_ADDR 0 and 4095) share one stimulus stream;
// writes are checked against words computed from the random payload.
module tb_ram_loader;
    localparam int DW = 32;
    localparam int AW = 12;
    localparam int MEM_NUM = 4096;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    logic in_ready, w_en, hold_o, busy, done, err;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic [AW:0] word_cnt;
    logic in_ready1, w_en1, hold1, busy1, done1, err1;
    logic [AW-1:0] w_addr1;
    logic [DW-1:0] w_data1;
    logic [AW:0] word_cnt1;

    ram_loader #(.DW(DW), .AW(AW), .MEM_NUM(MEM_NUM), .BASE_ADDR(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .w_en(w_en), .w_addr_o(w_addr), .w_data_o(w_data),
        .hold_o(hold_o), .busy(busy), .done(done), .err(err), .word_cnt(word_cnt));

    ram_loader #(.DW(DW), .AW(AW), .MEM_NUM(MEM_NUM), .BASE_ADDR(4095)) dut1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .w_en(w_en1), .w_addr_o(w_addr1), .w_data_o(w_data1),
        .hold_o(hold1), .busy(busy1), .done(done1), .err(err1), .word_cnt(word_cnt1));

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [1:0]    en;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [AW:0]   wc;
    } wr_t;
    wr_t mon_q[$];
    logic [7:0] data_b[$];

    typedef struct {
        int n;
        int gmax;
        bit chk_good;
        bit exp_done;
        bit exp_err;
        int exp_words;
    } vec_t;
    vec_t vq[$];

    always @(negedge clk) begin
        if (w_en || w_en1)
            mon_q.push_back('{{w_en, w_en1}, w_addr, w_addr1, w_data, w_data1, word_cnt});
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int k;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = b;
        for (k = 0; k < 20; k++) begin
            if (in_ready) begin
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        if (k == 20) begin
            total++;
            bad++;
            $display("FAIL handshake: byte 0x%0h not accepted within 20 cycles", b);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic [7:0] payload_sum();
        logic [7:0] s = 8'd0;
        foreach (data_b[i]) s = s + data_b[i];
        return s;
    endfunction

    task automatic run_load(input int n, input int gmax, input bit chk_good);
        logic [7:0] b;
        data_b.delete();
        mon_q.delete();
        pulse_start();
        send_byte(n[7:0], $urandom_range(0, gmax));
        send_byte(n[15:8], $urandom_range(0, gmax));
        if (n <= MEM_NUM) begin
            for (int i = 0; i < n * 4; i++) begin
                b = 8'($urandom);
                data_b.push_back(b);
                send_byte(b, $urandom_range(0, gmax));
            end
`ifdef RAM_LOADER_CHECKSUM_EN
            send_byte(chk_good ? 8'(8'd0 - payload_sum()) : 8'(8'd1 - payload_sum()), 0);
`endif
        end
        idle(3);
    endtask

    task automatic check_result(input int nw, input bit ed, input bit ee);
        logic [DW-1:0] expd;
        check("done", done, ed);
        check("err", err, ee);
        check("word_cnt", word_cnt, nw);
        check("in_ready after load", in_ready, 0);
        check("hold after load", hold_o, 0);
        check("busy after load", busy, 0);
        check("instances agree", {in_ready1, hold1, busy1, done1, err1, word_cnt1},
              {in_ready, hold_o, busy, done, err, word_cnt});
        check("write count", mon_q.size(), nw);
        for (int i = 0; i < nw && i < mon_q.size(); i++) begin
            expd = {data_b[4*i+3], data_b[4*i+2], data_b[4*i+1], data_b[4*i]};
            check("write enables", mon_q[i].en, 2'b11);
            check("write addr base0", mon_q[i].a0, i % 4096);
            check("write addr base4095", mon_q[i].a1, (4095 + i) % 4096);
            check("write data", mon_q[i].d0, expd);
            check("write data base4095", mon_q[i].d1, expd);
            check("word_cnt at write", mon_q[i].wc, i + 1);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", in_ready, 0);
        check("reset w_en", w_en, 0);
        check("reset w_addr", w_addr, 0);
        check("reset w_data", w_data, 0);
        check("reset hold", hold_o, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset err", err, 0);
        check("reset word_cnt", word_cnt, 0);
        rst = 1'b1;
        idle(2);

        // reference stream, with write-cycle and completion timing checked in place
        mon_q.delete();
        data_b.delete();
        q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int i = 2; i < q.size(); i++) data_b.push_back(q[i]);
        pulse_start();
        check("start busy", busy, 1);
        check("start hold", hold_o, 1);
        check("start in_ready", in_ready, 1);
        for (int i = 0; i < q.size(); i++) begin
            send_byte(q[i], 0);
            if (i == 5) begin
                check("first write w_en", w_en, 1);
                check("in_ready during write", in_ready, 1);
                check("first write word_cnt", word_cnt, 1);
                check("first write addr", w_addr, 0);
                check("first write data", w_data, 32'h12345678);
                check("hold during load", hold_o, 1);
            end
        end
`ifndef RAM_LOADER_CHECKSUM_EN
        check("last write w_en", w_en, 1);
        check("done with last write", done, 1);
        check("hold falls at done", hold_o, 0);
        check("word_cnt at done", word_cnt, 2);
`else
        check("last write w_en", w_en, 1);
        check("busy before checksum", busy, 1);
        send_byte(8'(8'd0 - payload_sum()), 0);
        check("done after checksum", done, 1);
`endif
        idle(3);
        check_result(2, 1, 0);

        // start in DONE clears done and re-enters the header phase
        pulse_start();
        check("restart done cleared", done, 0);
        check("restart busy", busy, 1);
        check("restart in_ready", in_ready, 1);
        check("restart word_cnt cleared", word_cnt, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef RAM_LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        idle(2);
        check("empty load done", done, 1);

        // table of randomized loads
        vq.push_back(vec_t'{2, 2, 1, 1, 0, 2});
        vq.push_back(vec_t'{1, 0, 1, 1, 0, 1});
        vq.push_back(vec_t'{0, 1, 1, 1, 0, 0});
        vq.push_back(vec_t'{4097, 0, 1, 0, 1, 0});
        vq.push_back(vec_t'{65535, 1, 1, 0, 1, 0});
        vq.push_back(vec_t'{7, 3, 1, 1, 0, 7});
        vq.push_back(vec_t'{4096, 0, 1, 1, 0, 4096});
`ifdef RAM_LOADER_CHECKSUM_EN
        vq.push_back(vec_t'{3, 1, 0, 0, 1, 3});
`endif
        for (int t = 0; t < vq.size(); t++) begin
            run_load(vq[t].n, vq[t].gmax, vq[t].chk_good);
            check_result(vq[t].exp_words, vq[t].exp_done, vq[t].exp_err);
        end

        // start in ERR clears err
        run_load(4097, 0, 1);
        pulse_start();
        check("restart err cleared", err, 0);
        check("restart from err busy", busy, 1);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
`ifdef RAM_LOADER_CHECKSUM_EN
        send_byte(8'h00, 0);
`endif
        idle(2);
        check("done after err restart", done, 1);

        // start pulsed mid-payload is ignored
        mon_q.delete();
        data_b.delete();
        for (int i = 0; i < 8; i++) data_b.push_back(8'($urandom));
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 3; i++) send_byte(data_b[i], 0);
        in_valid = 1'b0;
        pulse_start();
        for (int i = 3; i < 8; i++) send_byte(data_b[i], 1);
`ifdef RAM_LOADER_CHECKSUM_EN
        send_byte(8'(8'd0 - payload_sum()), 0);
`endif
        idle(3);
        check_result(2, 1, 0);

        // reset mid-load with valid toggling every other cycle
        mon_q.delete();
        data_b.delete();
        for (int i = 0; i < 12; i++) data_b.push_back(8'($urandom));
        pulse_start();
        send_byte(8'h03, 1);
        send_byte(8'h00, 1);
        for (int i = 0; i < 5; i++) send_byte(data_b[i], 1);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("midreset in_ready", in_ready, 0);
        check("midreset w_en", w_en, 0);
        check("midreset w_addr", w_addr, 0);
        check("midreset w_data", w_data, 0);
        check("midreset hold", hold_o, 0);
        check("midreset busy", busy, 0);
        check("midreset done", done, 0);
        check("midreset err", err, 0);
        check("midreset word_cnt", word_cnt, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(5);
        check("midreset write count", mon_q.size(), 1);
        if (mon_q.size() > 0)
            check("midreset write data", mon_q[0].d0,
                  {data_b[3], data_b[2], data_b[1], data_b[0]});
        check("idle after reset in_ready", in_ready, 0);
        check("idle after reset busy", busy, 0);

`ifdef RAM_LOADER_CHECKSUM_EN
        // checksum pass and fail on the same payload
        for (int pass = 0; pass < 2; pass++) begin
            mon_q.delete();
            data_b = '{8'h01, 8'h02, 8'h03, 8'h04};
            pulse_start();
            send_byte(8'h01, 0);
            send_byte(8'h00, 0);
            foreach (data_b[i]) send_byte(data_b[i], 0);
            send_byte(pass == 0 ? 8'hF6 : 8'hF5, 0);
            idle(2);
            check("checksum done", done, pass == 0);
            check("checksum err", err, pass == 1);
            check("checksum write count", mon_q.size(), 1);
            if (mon_q.size() > 0) check("checksum write data", mon_q[0].d0, 32'h04030201);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_loader.md
# ram_loader

Program loader sitting directly upstream of the `dual_ram` write port in the simulation/FPGA image. Accepts a length-prefixed byte stream (valid/ready), assembles little-endian DW-bit words and writes them into consecutive RAM addresses starting at BASE_ADDR. It also holds the core in reset while loading is in progress.

## Interface
- `DW`, 32: RAM word width; must be a multiple of 8; bytes per word BPW = DW/8.
- `AW`, 12: RAM address width.
- `MEM_NUM`, 4096: RAM depth in words; maximum accepted length.
- `BASE_ADDR`, 0: first RAM word address written.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a load.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  byte-stream data.
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`.
- `w_en`  out  1  RAM write enable, to `dual_ram.w_en`.
- `w_addr_o`  out  AW  RAM write address.
- `w_data_o`  out  DW  RAM write data.
- `hold_o`  out  1  keeps the core in reset; high from `start` until DONE/ERR.
- `busy`  out  1  high in HDR, DATA, CHK.
- `done`  out  1  load completed successfully; level.
- `err`  out  1  load aborted; level.
- `word_cnt`  out  AW+1  number of words written in the current load.

## Operation
- States: IDLE, HDR, DATA, CHK (present only with the macro), DONE, ERR.
- IDLE: `in_ready`=0. `start` -> HDR; clear `word_cnt`, `done`, `err`, byte index, checksum.
- HDR: `in_ready`=1. Accept 2 bytes, LSB first, forming 16-bit length N (words).
  - N=0 -> DONE (or CHK with the macro).
  - N>MEM_NUM -> ERR.
  - Otherwise -> DATA.
- DATA: `in_ready`=1. Bytes fill the word LSB first: byte k goes to bits [8k+7:8k].
  - On accepting byte BPW-1, issue one write: addr = (BASE_ADDR + word_cnt) mod 2^AW; wrap-around is silent. Increment `word_cnt` and reset the byte index.
  - After word N is accepted -> DONE (or CHK).
- DONE/ERR: `in_ready`=0; `done` or `err` held at 1. `start` re-enters HDR with flags cleared.
- `start` is ignored in HDR/DATA/CHK.
- `in_valid` may drop between bytes; there is no timeout.

## Timing
- Reset values: `in_ready`=0, `w_en`=0, `w_addr_o`=0, `w_data_o`=0, `hold_o`=0, `busy`=0, `done`=0, `err`=0, `word_cnt`=0. State returns to IDLE.
- Reset asserted mid-load: any pending write is dropped and no `w_en` is emitted after reset.
- `start` sampled at cycle T: state is HDR, `hold_o`=1 and `in_ready`=1 at T+1.
- Write latency: `w_en`=1 for exactly one cycle, in the cycle after the handshake of the word's final byte. `w_addr_o`/`w_data_o` are valid in that cycle and hold their values afterwards.
- Throughput: one byte per cycle sustained; `in_ready` does not drop during a write cycle.
- `word_cnt` updates in the same cycle `w_en` is high.
- State change to DONE/ERR/CHK is visible the cycle after the deciding byte's handshake. The final `w_en` and the first `done` cycle coincide (no macro).
- `hold_o` falls in the first DONE/ERR cycle.

## Configuration
- `RAM_LOADER_CHECKSUM_EN` defined:
  - After the last data word (or after the header when N=0), CHK accepts one byte C.
  - If (8-bit sum of all data bytes + C) mod 256 == 0 -> DONE, else -> ERR.
  - Words already written stay in RAM.
- Undefined: the CHK state and checksum logic are absent; the last data byte leads straight to DONE.

## Test plan
- BASE_ADDR=0, `start`, stream 02 00 | 78 56 34 12 | EF BE AD DE -> writes 0x12345678@0, 0xDEADBEEF@1; `done`=1, `word_cnt`=2, `hold_o`=0.
- BASE_ADDR=4095, N=2 -> writes at addresses 4095 then 0 (wrap); `done`=1.
- Header 01 10 (N=4097) -> ERR, no `w_en` ever asserted, `err`=1, `in_ready`=0.
- N=3 with `in_valid` toggling every other cycle, reset asserted after 5 data bytes -> all outputs 0 at once, exactly one write seen, IDLE.
- Macro on: N=1, data 01 02 03 04, C=0xF6 -> `done`. Same data with C=0xF5 -> `err`, and word 0x04030201 already written.
- `start` pulsed in DATA -> ignored. `start` in DONE -> HDR with `done` cleared next cycle.
